keypot_responder: RTL and testbench
===================================

KEYPOT_RESPONDER -- requirements
Module: keypot_responder

Interface
REQ-001 The block SHALL have one parameter: POT_MAX, default 228, the last pot count value and the clamp ceiling for pot targets.
REQ-002 The block SHALL have port clk179, input, 1 bit, the single clock; every register is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-004 The block SHALL have port key_scan_L, input, 4 bits, the active-low key scan index driven by POKEY.
REQ-005 The block SHALL have port kr1_L, output, 1 bit, the active-low key-return line.
REQ-006 The block SHALL have port key_wr_valid, input, 1 bit, the host key-event strobe.
REQ-007 The block SHALL have port key_wr_code, input, 4 bits, the key index of the event.
REQ-008 The block SHALL have port key_wr_down, input, 1 bit: 1 = press, 0 = release.
REQ-009 The block SHALL have port key_wr_ready, output, 1 bit, which is always 1 when rst is low.
REQ-010 The block SHALL have port pot_rel, input, 1 bit, the POKEY dump-transistor control; 1 = capacitors dumped.
REQ-011 The block SHALL have port pot_tick, input, 1 bit, a one-cycle strobe per POKEY pot count.
REQ-012 The block SHALL have port pot_val, input, 32 bits, four 8-bit host targets; bits [8i+7:8i] belong to line i.
REQ-013 The block SHALL have port pot_scan_in, output, 4 bits, the pot comparator lines to POKEY.
REQ-014 The block SHALL have port pot_busy, output, 1 bit, which is high while in COUNT.

Function
REQ-015 The block SHALL keep key state in a 16-bit key_state register; an accepted event (key_wr_valid and key_wr_ready) sets or clears bit key_wr_code on the next edge.
REQ-016 The block SHALL register kr1_L as the inverse of key_state[~key_scan_L], giving a latency of 1 cycle.
REQ-017 The block SHALL let a release event arriving on the same edge as a hold-counter update take priority; under KEYPOT_HOLD_EN that release is deferred, never dropped.
REQ-018 The pot sequencer SHALL implement exactly the states DUMP, COUNT and DONE.
REQ-019 In DUMP: pot_scan_in = 0 and cnt = 0; a pot_rel falling edge (registered pot_rel 1 -> 0) moves the sequencer to COUNT and loads shadow targets sh_i = min(pot_val byte i, POT_MAX).
REQ-020 In COUNT: each pot_tick increments cnt; pot_scan_in[i] = (cnt >= sh_i), registered.
REQ-021 In COUNT: cnt saturates at POT_MAX; when cnt == POT_MAX or all pot_scan_in bits are 1, the sequencer moves to DONE.
REQ-022 In DONE: pot_scan_in holds at 4'hF until pot_rel = 1.
REQ-023 In any state, pot_rel = 1 SHALL force DUMP on the next edge, including mid-COUNT, where it abandons the scan.
REQ-024 pot_val changes during COUNT SHALL have no effect until the next COUNT entry.
REQ-025 A target of 0 SHALL assert its pot_scan_in line in the first COUNT cycle, before any tick.

Reset
REQ-026 While rst = 1, the block SHALL set key_state = 0, kr1_L = 1, key_wr_ready = 0, state = DUMP, cnt = 0, pot_scan_in = 0, pot_busy = 0, all hold counters = 0 and all pending releases = 0.
REQ-027 The block SHALL make the first accepted key event possible in the cycle after rst falls.

Configuration
REQ-028 With KEYPOT_HOLD_EN defined, each key SHALL carry a 2-bit visit counter, cleared on press and incremented when the scan index equals the key while its bit is set; a release is deferred until the counter reaches 2, so POKEY's two-pass debounce always sees the key.
REQ-029 Without KEYPOT_HOLD_EN, a release SHALL clear key_state immediately and no hold counters SHALL exist.

Structure
REQ-030 The package keypot_pkg SHALL hold the pot state enum (DUMP/COUNT/DONE), POT_MAX_DEFAULT = 228 and HOLD_SCANS = 2.
REQ-031 The pot state machine, cnt and shadow targets SHALL live in one sub-module, keypot_pot_seq; key logic stays in the top.

Verification
REQ-032 Press key 5 and sweep key_scan_L over 16 values -> kr1_L = 0 exactly one cycle after key_scan_L = 4'hA, and 1 otherwise.
REQ-033 pot_val = 32'h00_E8_40_10 with pot_rel 1 -> 0 and one tick per 4 cycles -> pot_scan_in[0] rises at cnt = 16, [1] at 64, [2] at 228 (232 clamped), [3] in the first COUNT cycle; the sequencer then enters DONE.
REQ-034 Assert pot_rel = 1 at cnt = 100 -> pot_scan_in = 0 and DUMP next edge; the next fall restarts from cnt = 0.
REQ-035 Change pot_val mid-COUNT -> thresholds unchanged until the following scan.
REQ-036 KEYPOT_HOLD_EN: press then release key 3 within 4 cycles -> kr1_L low on two visits of index 3, then high; without the macro -> at most one low visit.
REQ-037 Assert rst mid-COUNT with key 7 held -> all outputs at reset values next edge; kr1_L stays 1 for a full scan.

Source files
------------

// File: rtl/keypot_pkg.sv
// -----------------------------------------------------------------------------
// keypot_pkg
// Shared types and constants for the POKEY key / pot responder.
//   pot_state_e     : pot sequencer states (dump, count, done)
//   POT_MAX_DEFAULT : default last pot count and target clamp ceiling
//   HOLD_SCANS      : keyboard visits a key must get before a release lands
//                     (only used when KEYPOT_HOLD_EN is defined)
//   clamp_target()  : clamps an 8-bit host target to the pot ceiling
// -----------------------------------------------------------------------------
package keypot_pkg;

    typedef enum logic [1:0] {
        StDump  = 2'd0,
        StCount = 2'd1,
        StDone  = 2'd2
    } pot_state_e;

    localparam int unsigned POT_MAX_DEFAULT = 228;
    localparam int unsigned HOLD_SCANS      = 2;

    function automatic logic [7:0] clamp_target(input logic [7:0] target,
                                                input logic [7:0] ceiling);
        return (target > ceiling) ? ceiling : target;
    endfunction

endpackage

// File: rtl/keypot_pot_seq.sv
// -----------------------------------------------------------------------------
// keypot_pot_seq
// Emulates the four POKEY pot capacitor lines. While the dump transistors are
// on the lines read 0; when they are released the block counts pot ticks and
// raises each line once the count reaches that line's (clamped) host target.
// Targets are latched when counting starts, so host writes mid-scan only take
// effect on the next scan.
//
// Ports
//   clk179      in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   pot_rel     in   1 = capacitors dumped; its registered 1->0 edge starts a scan
//   pot_tick    in   one-cycle strobe per POKEY pot count
//   pot_val     in   four 8-bit targets, byte i belongs to line i
//   pot_scan_in out  registered comparator lines to POKEY
//   pot_busy    out  high while counting
// -----------------------------------------------------------------------------
module keypot_pot_seq
    import keypot_pkg::*;
#(
    parameter int unsigned POT_MAX = POT_MAX_DEFAULT
) (
    input  logic        clk179,
    input  logic        rst,
    input  logic        pot_rel,
    input  logic        pot_tick,
    input  logic [31:0] pot_val,
    output logic [3:0]  pot_scan_in,
    output logic        pot_busy
);

    localparam logic [7:0] PotMax = 8'(POT_MAX);

    pot_state_e       state;
    logic [7:0]       cnt;
    logic [3:0][7:0]  sh;
    logic             rel_q;

    logic [7:0]       cnt_inc;
    logic [3:0][7:0]  tgt;
    logic [3:0]       hit_next;
    logic [3:0]       hit_zero;

    always_comb begin
        cnt_inc  = (pot_tick && (cnt < PotMax)) ? cnt + 8'd1 : cnt;
        tgt      = '0;
        hit_next = '0;
        hit_zero = '0;
        for (int i = 0; i < 4; i++) begin
            tgt[i]      = clamp_target(pot_val[8*i +: 8], PotMax);
            // Compare against the post-tick count so a line rises in the
            // same cycle the count reaches its target.
            hit_next[i] = (cnt_inc >= sh[i]);
            // Zero targets must read high in the very first counting cycle.
            hit_zero[i] = (tgt[i] == 8'd0);
        end
    end

    always_ff @(posedge clk179) begin
        if (rst) begin
            state       <= StDump;
            cnt         <= '0;
            sh          <= '0;
            rel_q       <= 1'b0;
            pot_scan_in <= '0;
            pot_busy    <= 1'b0;
        end else begin
            rel_q <= pot_rel;
            if (pot_rel) begin
                // Dumping overrides everything, abandoning any scan in flight.
                state       <= StDump;
                cnt         <= '0;
                pot_scan_in <= '0;
                pot_busy    <= 1'b0;
            end else begin
                case (state)
                    StDump: begin
                        cnt         <= '0;
                        pot_scan_in <= '0;
                        if (rel_q) begin
                            state       <= StCount;
                            sh          <= tgt;
                            pot_scan_in <= hit_zero;
                            pot_busy    <= 1'b1;
                        end
                    end
                    StCount: begin
                        if ((cnt == PotMax) || (&pot_scan_in)) begin
                            state       <= StDone;
                            pot_scan_in <= 4'hF;
                            pot_busy    <= 1'b0;
                        end else begin
                            cnt         <= cnt_inc;
                            pot_scan_in <= hit_next;
                        end
                    end
                    StDone: begin
                        pot_scan_in <= 4'hF;
                        pot_busy    <= 1'b0;
                    end
                    default: begin
                        state       <= StDump;
                        cnt         <= '0;
                        pot_scan_in <= '0;
                        pot_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypot_responder.sv
// -----------------------------------------------------------------------------
// keypot_responder
// Answers POKEY's keyboard scan and pot comparator lines on behalf of a host.
// The host posts key press/release events; the block returns the active-low
// key-return line for whichever key index POKEY is scanning. Pot handling
// lives in keypot_pot_seq.
//
// Build option: define KEYPOT_HOLD_EN to hold a released key until POKEY has
// visited it HOLD_SCANS times since its press, so the two-pass debounce never
// misses a short tap. Without it a release clears the key immediately.
//
// Ports
//   clk179       in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   key_scan_L   in   active-low key scan index from POKEY
//   kr1_L        out  registered active-low key-return line
//   key_wr_valid in   host key-event strobe
//   key_wr_code  in   key index of the event
//   key_wr_down  in   1 = press, 0 = release
//   key_wr_ready out  1 whenever rst is low
//   pot_rel      in   POKEY dump-transistor control, 1 = dumped
//   pot_tick     in   one-cycle strobe per pot count
//   pot_val      in   four 8-bit pot targets
//   pot_scan_in  out  pot comparator lines to POKEY
//   pot_busy     out  high while the pot sequencer is counting
// -----------------------------------------------------------------------------
module keypot_responder
    import keypot_pkg::*;
#(
    parameter int unsigned POT_MAX = POT_MAX_DEFAULT
) (
    input  logic        clk179,
    input  logic        rst,
    input  logic [3:0]  key_scan_L,
    output logic        kr1_L,
    input  logic        key_wr_valid,
    input  logic [3:0]  key_wr_code,
    input  logic        key_wr_down,
    output logic        key_wr_ready,
    input  logic        pot_rel,
    input  logic        pot_tick,
    input  logic [31:0] pot_val,
    output logic [3:0]  pot_scan_in,
    output logic        pot_busy
);

    logic [15:0] key_state;
    logic [3:0]  scan_idx;
    logic        key_accept;

    // Combinational so an event can be taken in the first cycle out of reset.
    assign key_wr_ready = ~rst;
    assign key_accept   = key_wr_valid & key_wr_ready;
    assign scan_idx     = ~key_scan_L;

    always_ff @(posedge clk179) begin
        if (rst) begin
            kr1_L <= 1'b1;
        end else begin
            kr1_L <= ~key_state[scan_idx];
        end
    end

`ifdef KEYPOT_HOLD_EN
    localparam logic [1:0] HoldScans = 2'(HOLD_SCANS);

    logic [15:0][1:0] hold_cnt;
    logic [15:0]      pend_rel;

    // Later assignments in this block win, so a host event on the same edge
    // as a visit or a deferred release takes priority over both.
    always_ff @(posedge clk179) begin
        if (rst) begin
            key_state <= '0;
            hold_cnt  <= '0;
            pend_rel  <= '0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (key_state[k] && (scan_idx == 4'(k)) && (hold_cnt[k] < HoldScans)) begin
                    hold_cnt[k] <= hold_cnt[k] + 2'd1;
                end
                if (pend_rel[k] && (hold_cnt[k] >= HoldScans)) begin
                    key_state[k] <= 1'b0;
                    pend_rel[k]  <= 1'b0;
                end
            end
            if (key_accept) begin
                if (key_wr_down) begin
                    key_state[key_wr_code] <= 1'b1;
                    hold_cnt[key_wr_code]  <= 2'd0;
                    pend_rel[key_wr_code]  <= 1'b0;
                end else if (!key_state[key_wr_code] ||
                             (hold_cnt[key_wr_code] >= HoldScans)) begin
                    key_state[key_wr_code] <= 1'b0;
                    pend_rel[key_wr_code]  <= 1'b0;
                end else begin
                    // Not seen often enough yet: remember the release.
                    pend_rel[key_wr_code] <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk179) begin
        if (rst) begin
            key_state <= '0;
        end else if (key_accept) begin
            key_state[key_wr_code] <= key_wr_down;
        end
    end
`endif

    keypot_pot_seq #(
        .POT_MAX (POT_MAX)
    ) u_pot_seq (
        .clk179      (clk179),
        .rst         (rst),
        .pot_rel     (pot_rel),
        .pot_tick    (pot_tick),
        .pot_val     (pot_val),
        .pot_scan_in (pot_scan_in),
        .pot_busy    (pot_busy)
    );

endmodule

// File: tb/tb_keypot_responder.sv
module tb_keypot_responder;

    localparam int unsigned PotMax = 228;
`ifdef KEYPOT_HOLD_EN
    localparam int ExpLows = 2;
`else
    localparam int ExpLows = 1;
`endif

    logic        clk179 = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_scan_L = 4'hF;
    logic        kr1_L;
    logic        key_wr_valid = 1'b0;
    logic [3:0]  key_wr_code = 4'd0;
    logic        key_wr_down = 1'b0;
    logic        key_wr_ready;
    logic        pot_rel = 1'b0;
    logic        pot_tick = 1'b0;
    logic [31:0] pot_val = 32'd0;
    logic [3:0]  pot_scan_in;
    logic        pot_busy;

    always #5 clk179 = ~clk179;

    keypot_responder #(
        .POT_MAX (PotMax)
    ) dut (
        .clk179       (clk179),
        .rst          (rst),
        .key_scan_L   (key_scan_L),
        .kr1_L        (kr1_L),
        .key_wr_valid (key_wr_valid),
        .key_wr_code  (key_wr_code),
        .key_wr_down  (key_wr_down),
        .key_wr_ready (key_wr_ready),
        .pot_rel      (pot_rel),
        .pot_tick     (pot_tick),
        .pot_val      (pot_val),
        .pot_scan_in  (pot_scan_in),
        .pot_busy     (pot_busy)
    );

    int tests = 0;
    int fails = 0;

    // Scoreboard: expectations are queued when inputs are driven and popped
    // one cycle later, when the registered outputs reflect them.
    logic       exp_kr1_q[$];
    logic [3:0] exp_pot_q[$];
    int         idx_q[$];

    int          low_visits = 0;
    logic        last_kr1_at3 = 1'b0;
    logic [31:0] shadow = 32'd0;
    int          ticks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic step();
        int   idx;
        logic e1;
        logic [3:0] e4;
        @(negedge clk179);
        if (exp_kr1_q.size() > 0) begin
            e1 = exp_kr1_q.pop_front();
            check("kr1_L", {31'd0, kr1_L}, {31'd0, e1});
        end
        if (exp_pot_q.size() > 0) begin
            e4 = exp_pot_q.pop_front();
            check("pot_scan_in", {28'd0, pot_scan_in}, {28'd0, e4});
        end
        if (idx_q.size() > 0) begin
            idx = idx_q.pop_front();
            if (idx == 3) begin
                if (kr1_L === 1'b0) low_visits++;
                last_kr1_at3 = kr1_L;
            end
        end
    endtask

    // Line i is high once the tick count since the scan started reaches
    // its target, clamped to PotMax.
    function automatic logic [3:0] exp_scan(input int t, input logic [31:0] tv);
        logic [3:0] r;
        int th;
        for (int i = 0; i < 4; i++) begin
            th = int'(tv[8*i +: 8]);
            if (th > int'(PotMax)) th = int'(PotMax);
            r[i] = (t >= th);
        end
        return r;
    endfunction

    task automatic push_pot();
        exp_pot_q.push_back(exp_scan(ticks, shadow));
    endtask

    // Releases the dump transistors with new targets: pot_rel must already be 1.
    task automatic start_scan(input logic [31:0] tv);
        pot_rel = 1'b0;
        pot_val = tv;
        shadow  = tv;
        ticks   = 0;
        push_pot();
        step();
    endtask

    task automatic tick_once();
        pot_tick = 1'b1;
        ticks++;
        push_pot();
        step();
        pot_tick = 1'b0;
    endtask

    task automatic dump_cycle();
        pot_rel = 1'b1;
        exp_pot_q.push_back(4'h0);
        step();
    endtask

    initial begin
        // Reset, with a press of key 2 that must be ignored while rst is high.
        rst          = 1'b1;
        key_wr_valid = 1'b1;
        key_wr_code  = 4'd2;
        key_wr_down  = 1'b1;
        step();
        step();
        step();
        check("rst_kr1_L", {31'd0, kr1_L}, 32'd1);
        check("rst_ready", {31'd0, key_wr_ready}, 32'd0);
        check("rst_pot_scan", {28'd0, pot_scan_in}, 32'd0);
        check("rst_pot_busy", {31'd0, pot_busy}, 32'd0);

        // Press key 5 in the first cycle out of reset.
        rst         = 1'b0;
        key_wr_code = 4'd5;
        step();
        check("ready_after_rst", {31'd0, key_wr_ready}, 32'd1);
        key_wr_valid = 1'b0;

        // Sweep every scan value: only 4'hA (index 5) returns a key.
        for (int s = 0; s < 16; s++) begin
            key_scan_L = 4'(s);
            exp_kr1_q.push_back((s == 10) ? 1'b0 : 1'b1);
            step();
        end

        // Short tap of key 3 against a running keyboard scan.
        low_visits = 0;
        for (int sw = 0; sw < 4; sw++) begin
            for (int i = 0; i < 16; i++) begin
                key_scan_L   = ~4'(i);
                key_wr_valid = 1'b0;
                if (sw == 0 && i == 1) begin
                    key_wr_valid = 1'b1;
                    key_wr_code  = 4'd3;
                    key_wr_down  = 1'b1;
                end
                if (sw == 0 && i == 4) begin
                    key_wr_valid = 1'b1;
                    key_wr_code  = 4'd3;
                    key_wr_down  = 1'b0;
                end
                idx_q.push_back(i);
                step();
            end
        end
        key_wr_valid = 1'b0;
        check("tap_low_visits", 32'(low_visits), 32'(ExpLows));
        check("tap_released", {31'd0, last_kr1_at3}, 32'd1);

        // Full pot scan: 16 / 64 / 232->228 / 0, one tick every 4 cycles.
        exp_pot_q.push_back(4'h0);
        step();
        dump_cycle();
        dump_cycle();
        start_scan(32'h00_E8_40_10);
        check("first_count_cycle", {28'd0, pot_scan_in}, 32'h8);
        for (int t = 1; t <= int'(PotMax); t++) begin
            for (int c = 0; c < 4; c++) begin
                pot_tick = (c == 0);
                if (c == 0) ticks++;
                push_pot();
                step();
                if (t == 100 && c == 0) check("busy_mid_count", {31'd0, pot_busy}, 32'd1);
            end
        end
        pot_tick = 1'b0;
        check("done_busy", {31'd0, pot_busy}, 32'd0);
        exp_pot_q.push_back(4'hF);
        step();

        // Abort at cnt = 100, then restart from zero with low targets.
        dump_cycle();
        start_scan(32'hC8C8C8C8);
        for (int t = 0; t < 100; t++) tick_once();
        dump_cycle();
        check("abort_busy", {31'd0, pot_busy}, 32'd0);
        start_scan(32'h05050505);
        for (int t = 0; t < 8; t++) tick_once();

        // Targets written mid-scan wait for the next scan.
        dump_cycle();
        start_scan(32'h30303030);
        for (int t = 1; t <= 50; t++) begin
            if (t == 10) pot_val = 32'h0C0C0C0C;
            tick_once();
        end
        dump_cycle();
        start_scan(32'h0C0C0C0C);
        for (int t = 0; t < 14; t++) tick_once();

        // Reset mid-count with key 7 held.
        key_wr_valid = 1'b1;
        key_wr_code  = 4'd7;
        key_wr_down  = 1'b1;
        step();
        key_wr_valid = 1'b0;
        key_scan_L   = 4'h8;
        dump_cycle();
        exp_kr1_q.push_back(1'b0);
        pot_rel = 1'b0;
        pot_val = 32'h50505050;
        shadow  = pot_val;
        ticks   = 0;
        push_pot();
        step();
        for (int t = 0; t < 3; t++) begin
            exp_kr1_q.push_back(1'b0);
            tick_once();
        end
        check("busy_before_rst", {31'd0, pot_busy}, 32'd1);
        rst = 1'b1;
        pot_tick = 1'b1;
        exp_kr1_q.push_back(1'b1);
        exp_pot_q.push_back(4'h0);
        step();
        pot_tick = 1'b0;
        check("midrst_busy", {31'd0, pot_busy}, 32'd0);
        check("midrst_ready", {31'd0, key_wr_ready}, 32'd0);
        rst = 1'b0;
        for (int s = 0; s < 16; s++) begin
            key_scan_L = 4'(s);
            exp_kr1_q.push_back(1'b1);
            exp_pot_q.push_back(4'h0);
            step();
        end
        check("post_rst_ready", {31'd0, key_wr_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
